// File: rtl/key_gen.sv
// Ring-LWE key generator: serially loads a, s and e, then computes b = a*s + e in Z_p[x]/(x^N+1)
// with one multiply-accumulate per cycle, then streams out (a, b, s).
module key_gen #(
    parameter int p     = 17,
    parameter int logP  = 5,
    parameter int N     = 8,
    parameter int logN  = 3,
    parameter int N_inv = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            TRNG_ready,
    input  logic [logP-1:0] TRNG_in,
    input  logic            Gaussian_ready,
    input  logic [logP-1:0] Gaussian_in,
    output logic [logP-1:0] pub_key_a,
    output logic [logP-1:0] pub_key_b,
    output logic [logP-1:0] sec_key_s,
    output logic            key_ready
);
    localparam int PW = 2 * logP;
    localparam int CW = 2 * logN;
    localparam logic [logP-1:0] P_R = logP'(p);
    localparam logic [logP:0]   P_X = (logP + 1)'(p);
    localparam logic [PW-1:0]   P_W = PW'(p);

    if (N != (1 << logN) || ((N * N_inv) % p) != 1) begin : g_bad_params
        $error("key_gen: inconsistent N/logN/N_inv/p");
    end

    typedef enum logic [3:0] {
        IDLE, ARM, LOAD_A, GAP_S, LOAD_S, GAP_E, LOAD_E, COMPUTE, OUTPUT
    } state_t;

    state_t state, state_nx;
    logic [N-1:0][logP-1:0] a_mem, s_mem, e_mem, b_mem;
    logic [logN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [logP-1:0] acc;
    logic cap_a, cap_s, cap_e, mac_en, out_en;
    logic idx_last, cnt_last;

    function automatic logic [logP-1:0] reduce(input logic [logP-1:0] v);
        return (v >= P_R) ? v - P_R : v;
    endfunction

    assign idx_last = (idx == '1);
    assign cnt_last = (cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ARM with start low acts as the first LOAD_A cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ARM;
            ARM:     if (!start) state_nx = (cap_a && idx_last) ? GAP_S : LOAD_A;
            LOAD_A:  if (cap_a && idx_last) state_nx = GAP_S;
            GAP_S:   state_nx = LOAD_S;
            LOAD_S:  if (cap_s && idx_last) state_nx = GAP_E;
            GAP_E:   state_nx = LOAD_E;
            LOAD_E:  if (cap_e && idx_last) state_nx = COMPUTE;
            COMPUTE: if (cnt_last) state_nx = OUTPUT;
            OUTPUT:  if (idx_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cap_a  = (state == ARM || state == LOAD_A) && TRNG_ready && !start;
        cap_s  = (state == LOAD_S) && Gaussian_ready;
        cap_e  = (state == LOAD_E) && Gaussian_ready;
        mac_en = (state == COMPUTE);
        out_en = (state == OUTPUT);
    end

    // Negacyclic MAC: index j wraps mod N, terms with i > k carry a minus sign
    logic [logN-1:0] k, i, j;
    logic [PW-1:0]   prod;
    logic [logP-1:0] term, base, add_r, sub_r, acc_nx;
    logic [logP:0]   sum;

    always_comb begin
        k      = cnt[CW-1:logN];
        i      = cnt[logN-1:0];
        j      = k - i;
        prod   = PW'(a_mem[i]) * PW'(s_mem[j]);
        term   = logP'(prod % P_W);
        base   = (i == '0) ? e_mem[k] : acc;
        sum    = {1'b0, base} + {1'b0, term};
        add_r  = (sum >= P_X) ? logP'(sum - P_X) : sum[logP-1:0];
        sub_r  = (base >= term) ? base - term : logP'({1'b0, base} + P_X - {1'b0, term});
        acc_nx = (i <= k) ? add_r : sub_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mem     <= '0;
            s_mem     <= '0;
            e_mem     <= '0;
            b_mem     <= '0;
            idx       <= '0;
            cnt       <= '0;
            acc       <= '0;
            pub_key_a <= '0;
            pub_key_b <= '0;
            sec_key_s <= '0;
            key_ready <= 1'b0;
        end else begin
            if (cap_a) a_mem[idx] <= reduce(TRNG_in);
            if (cap_s) s_mem[idx] <= reduce(Gaussian_in);
            if (cap_e) e_mem[idx] <= reduce(Gaussian_in);
            if (cap_a || cap_s || cap_e || out_en) idx <= idx + 1'b1;
            if (mac_en) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
                if (i == '1) b_mem[k] <= acc_nx;
            end
            key_ready <= out_en;
            pub_key_a <= out_en ? a_mem[idx] : '0;
            pub_key_b <= out_en ? b_mem[idx] : '0;
            sec_key_s <= out_en ? s_mem[idx] : '0;
        end
    end
endmodule

// File: tb/tb_key_gen.sv
// Directed bench for key_gen: hand-computed key vectors, stalls, input reduction and resets.
module tb_key_gen;
    localparam int N = 8;
    typedef int vec_t [N];

    logic clk = 1'b0;
    logic reset, start, TRNG_ready, Gaussian_ready;
    logic [4:0] TRNG_in, Gaussian_in;
    logic [4:0] pub_key_a, pub_key_b, sec_key_s;
    logic key_ready;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    key_gen dut (
        .clk(clk), .reset(reset), .start(start),
        .TRNG_ready(TRNG_ready), .TRNG_in(TRNG_in),
        .Gaussian_ready(Gaussian_ready), .Gaussian_in(Gaussian_in),
        .pub_key_a(pub_key_a), .pub_key_b(pub_key_b), .sec_key_s(sec_key_s),
        .key_ready(key_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_t a_seq   = '{1, 2, 3, 4, 5, 6, 7, 8};
    vec_t s_def   = '{0, 1, 0, 1, 0, 1, 0, 1};
    vec_t e_def   = '{1, 1, 0, 1, 1, 0, 0, 0};
    vec_t b_def   = '{15, 4, 1, 10, 10, 2, 4, 16};
    vec_t s_d0    = '{1, 0, 0, 0, 0, 0, 0, 0};
    vec_t s_d1    = '{0, 1, 0, 0, 0, 0, 0, 0};
    vec_t zeros   = '{0, 0, 0, 0, 0, 0, 0, 0};
    vec_t b_wrap  = '{9, 1, 2, 3, 4, 5, 6, 7};
    vec_t all18   = '{18, 18, 18, 18, 18, 18, 18, 18};
    vec_t ones    = '{1, 1, 1, 1, 1, 1, 1, 1};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input vec_t a, input vec_t s, input vec_t e,
                             input int stall_at, input int stall_len, output int t0);
        t0 = cyc;
        start = 1'b1;
        step;
        step;
        start = 1'b0;
        for (int n = 0; n < N; n++) begin
            TRNG_ready = 1'b1;
            TRNG_in = 5'(a[n]);
            step;
        end
        TRNG_ready = 1'b0;
        TRNG_in = 5'd0;
        step;
        for (int n = 0; n < N; n++) begin
            if (n == stall_at) begin
                Gaussian_ready = 1'b0;
                Gaussian_in = 5'd7;
                repeat (stall_len) step;
            end
            Gaussian_ready = 1'b1;
            Gaussian_in = 5'(s[n]);
            step;
        end
        Gaussian_ready = 1'b0;
        step;
        for (int n = 0; n < N; n++) begin
            Gaussian_ready = 1'b1;
            Gaussian_in = 5'(e[n]);
            step;
        end
        Gaussian_ready = 1'b0;
        Gaussian_in = 5'd0;
    endtask

    task automatic collect(input int t0, output vec_t ga, output vec_t gb, output vec_t gs,
                           output int lat, output logic kr_after);
        int w;
        w = 0;
        ga = zeros;
        gb = zeros;
        gs = zeros;
        while (!key_ready && w < 300) begin
            step;
            w++;
        end
        lat = key_ready ? cyc - t0 : -1;
        for (int n = 0; n < N; n++) begin
            ga[n] = int'(pub_key_a);
            gb[n] = int'(pub_key_b);
            gs[n] = int'(sec_key_s);
            step;
        end
        kr_after = key_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        TRNG_ready = 1'b0;
        TRNG_in = '0;
        Gaussian_ready = 1'b0;
        Gaussian_in = '0;
        #3;
        checks++;
        if (key_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_key_ready got=%b want=0", key_ready);
        end
        checks++;
        if ({pub_key_a, pub_key_b, sec_key_s} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got a=%0d b=%0d s=%0d want 0", pub_key_a, pub_key_b, sec_key_s);
        end
        step;
        reset = 1'b0;
        step;
    endtask

    task automatic run_and_check(input string name, input vec_t a, input vec_t s, input vec_t e,
                                 input vec_t a_exp, input vec_t b_exp, input int stall_len,
                                 input int lat_exp);
        vec_t ga, gb, gs;
        int t0, lat;
        logic kr;
        load_keys(a, s, e, (stall_len > 0) ? 4 : -1, stall_len, t0);
        collect(t0, ga, gb, gs, lat, kr);
        for (int n = 0; n < N; n++) begin
            checks++;
            if (gb[n] !== b_exp[n]) begin
                failures++;
                $display("FAIL %s_b[%0d] got=%0d want=%0d", name, n, gb[n], b_exp[n]);
            end
            checks++;
            if (ga[n] !== a_exp[n] || gs[n] !== s[n]) begin
                failures++;
                $display("FAIL %s_as[%0d] got a=%0d s=%0d want a=%0d s=%0d", name, n, ga[n], gs[n], a_exp[n], s[n]);
            end
        end
        checks++;
        if (lat !== lat_exp) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, lat_exp);
        end
        checks++;
        if (kr !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_width key_ready still %b after %0d outputs", name, kr, N);
        end
        step;
    endtask

    // start at edge 1, a at edges 3..10, s at 12..19, e at 21..28, ready seen after edge 28+65
    task automatic test_default;    run_and_check("default", a_seq, s_def, e_def, a_seq, b_def, 0, 93); endtask
    task automatic test_identity;   run_and_check("identity", a_seq, s_d0, zeros, a_seq, a_seq, 0, 93); endtask
    task automatic test_wrap;       run_and_check("wrap", a_seq, s_d1, zeros, a_seq, b_wrap, 0, 93); endtask
    task automatic test_reduction;  run_and_check("reduce", all18, s_d0, zeros, ones, ones, 0, 93); endtask
    task automatic test_stall;      run_and_check("stall", a_seq, s_def, e_def, a_seq, b_def, 3, 96); endtask

    task automatic test_reset_mid_run;
        int t0, w, seen;
        load_keys(a_seq, s_def, e_def, -1, 0, t0);
        repeat (10) step;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b0 || {pub_key_a, pub_key_b, sec_key_s} !== 15'd0) begin
            failures++;
            $display("FAIL reset_compute got kr=%b a=%0d b=%0d s=%0d want all 0", key_ready, pub_key_a, pub_key_b, sec_key_s);
        end
        step;
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            step;
            if (key_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_no_partial got %0d ready cycles want 0", seen);
        end
        // reset while outputs are live must clear them without a clock edge
        load_keys(a_seq, s_def, e_def, -1, 0, t0);
        w = 0;
        while (!key_ready && w < 300) begin
            step;
            w++;
        end
        step;
        step;
        checks++;
        if (key_ready !== 1'b1 || pub_key_a !== 5'd3 || pub_key_b !== 5'd1) begin
            failures++;
            $display("FAIL output_k2 got kr=%b a=%0d b=%0d want kr=1 a=3 b=1", key_ready, pub_key_a, pub_key_b);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b0 || {pub_key_a, pub_key_b, sec_key_s} !== 15'd0) begin
            failures++;
            $display("FAIL reset_output got kr=%b a=%0d b=%0d s=%0d want all 0", key_ready, pub_key_a, pub_key_b, sec_key_s);
        end
        step;
        reset = 1'b0;
        step;
        run_and_check("after_reset", a_seq, s_def, e_def, a_seq, b_def, 0, 93);
    endtask

    initial begin
        test_reset;
        test_default;
        test_identity;
        test_wrap;
        test_reduction;
        test_stall;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_gen.md
# key_gen

Ring-LWE key-generation engine: computes public key b = a·s + e in Z_p[x]/(x^N + 1), a negacyclic convolution plus noise, all coefficients mod p. Coefficients arrive serially:
- a comes from a TRNG stream.
- s and e come from a Gaussian-sampler stream.

Sits between the entropy sources and the key store, then streams out (a, b, s) coefficient by coefficient.

## Interface
- p, 17: modulus (prime).
- logP, 5: coefficient width in bits.
- N, 8: polynomial degree (power of two).
- logN, 3: log2(N).
- N_inv, 15: N^-1 mod p. Kept for compatibility with NTT variants; the direct datapath does not use it.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  request a new key pair (sampled in IDLE).
- TRNG_ready  in  1  TRNG_in is valid this cycle.
- TRNG_in  in  logP  uniform coefficient of a.
- Gaussian_ready  in  1  Gaussian_in is valid this cycle.
- Gaussian_in  in  logP  coefficient of s, then of e (residue mod p).
- pub_key_a  out  logP  a[k] during output phase.
- pub_key_b  out  logP  b[k] during output phase.
- sec_key_s  out  logP  s[k] during output phase.
- key_ready  out  1  high while the three outputs carry valid coefficient k.

## Operation
- State machine: IDLE → ARM → LOAD_A → GAP_S → LOAD_S → GAP_E → LOAD_E → COMPUTE → OUTPUT → IDLE.
- IDLE: start=1 moves to ARM.
- ARM: stays while start=1.
- ARM, start=0: behaves as LOAD_A in that same cycle.
- LOAD_A: captures TRNG_in into a[idx] on each edge where TRNG_ready=1 and start=0.
  - idx runs 0..N-1; stalls while not ready.
  - After a[N-1] → GAP_S.
- GAP_S: exactly one cycle, no capture, then → LOAD_S.
- GAP_E: exactly one cycle, no capture, then → LOAD_E.
- LOAD_S / LOAD_E: capture Gaussian_in into s[idx] / e[idx] on edges with Gaussian_ready=1; N captures each.
- Input reduction: every captured value v ≥ p is stored as v − p. Values are treated as unsigned residues; negative noise is encoded as p−|x|.
- COMPUTE: serial multiply-accumulate, N·N cycles, k outer 0..N−1, i inner 0..N−1.
  - Accumulator init per k: e[k].
  - Each cycle: j = (k−i) mod N, term = a[i]·s[j] mod p.
  - If i ≤ k then acc = (acc + term) mod p, else acc = (acc − term) mod p.
  - At i=N−1, b[k] is written.
- Arithmetic widths:
  - Product is 2·logP bits.
  - Every reduction yields an exact residue in [0, p−1].
  - Subtraction adds p when the result would go negative.
- OUTPUT: N cycles with key_ready=1, index 0 first (pub_key_a=a[k], pub_key_b=b[k], sec_key_s=s[k]); then IDLE.
- Outside OUTPUT all three data outputs are 0 and key_ready=0.
- start outside IDLE/ARM is ignored.
- Reset at any time, including mid-load or mid-compute:
  - All outputs and key_ready go to 0 immediately.
  - FSM returns to IDLE and coefficient buffers are cleared.
  - No partial result is ever emitted.

## Timing
- Reset values: key_ready=0, pub_key_a=pub_key_b=sec_key_s=0, state IDLE.
- Edge T = capture of a[N−1] (no stalls): s[0] is captured at T+2; e[0] at T+2+N+1.
- Edge E = capture of e[N−1]: COMPUTE occupies edges E+1..E+N·N.
- key_ready rises after edge E+N·N+1 and stays high for exactly N cycles; outputs are registered.
- Ready stalls delay everything downstream by exactly the stall length.
- Default parameters: one run from last e to last output is 73 cycles.

## Test plan
- Default vector:
  - Stimulus: start pulse (2 cycles), then a=1..8, GAP_S, s=(0,1,0,1,0,1,0,1), GAP_E, e=(1,1,0,1,1,0,0,0).
  - Required response: b=[15,4,1,10,10,2,4,16]; a out=1..8; s out as loaded.
- s=(1,0,0,0,0,0,0,0), e=0, a=1..8 → b=[1,2,3,4,5,6,7,8].
- s=(0,1,0,0,0,0,0,0), e=0, a=1..8 → b=[9,1,2,3,4,5,6,7] (negacyclic wrap).
- TRNG_in=18 for all a, s=(1,0…), e=0 → a out and b all 1 (input reduction).
- Default vector with Gaussian_ready low for 3 cycles mid-s → same b; key_ready delayed by 3 cycles.
- Reset pulse during COMPUTE → key_ready/outputs 0 immediately; a fresh default run then yields the default b.
